// File: rtl/p_multiplier.sv
// p_multiplier: sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One partial-product add per BUSY cycle; the result is ready WIDTH cycles
// after the start edge.
//
// Handshake: a start is accepted on a 0->1 transition of input_ready, seen
// against a registered copy of input_ready, while the block is in IDLE or
// DONE. output_ready then drops. It rises together with the new product
// after WIDTH cycles and stays high until the next accepted start or reset.
// While the block is BUSY, input_ready transitions and operand changes are
// ignored; they are not queued.
//
// Build option: define P_MULTIPLIER_SIGNED_EN to treat a, b and product as
// two's complement. The default build is purely unsigned.
module p_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               input_ready,
  output logic               output_ready,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  // Counter runs 0..WIDTH-1; WIDTH >= 2 keeps CW >= 1.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             ir_q;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic             start;

`ifdef P_MULTIPLIER_SIGNED_EN
  logic neg;
  logic neg_q;

  // Signed build: iterate on magnitudes, then restore the sign on completion.
  always_comb begin
    a_op     = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    b_op     = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
    neg      = a[WIDTH-1] ^ b[WIDTH-1];
    partial  = mplier[0] ? mcand : '0;
    acc_next = acc + partial;
    result   = neg_q ? (~acc_next + {{(PW-1){1'b0}}, 1'b1}) : acc_next;
  end
`else
  // Unsigned build: operands are used as-is.
  always_comb begin
    a_op     = a;
    b_op     = b;
    partial  = mplier[0] ? mcand : '0;
    acc_next = acc + partial;
    result   = acc_next;
  end
`endif

  // A start is a fresh rising edge of input_ready. The state check is in the FSM.
  always_comb begin
    start = input_ready & ~ir_q;
  end

  // Control FSM plus the shift-and-add datapath. The final add goes straight into product.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      ir_q         <= 1'b0;
      cnt          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      output_ready <= 1'b0;
      product      <= '0;
`ifdef P_MULTIPLIER_SIGNED_EN
      neg_q        <= 1'b0;
`endif
    end else begin
      ir_q <= input_ready;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand        <= {{WIDTH{1'b0}}, a_op};
            mplier       <= b_op;
            acc          <= '0;
            cnt          <= '0;
            output_ready <= 1'b0;
            state        <= BUSY;
`ifdef P_MULTIPLIER_SIGNED_EN
            neg_q        <= neg;
`endif
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            product      <= result;
            output_ready <= 1'b1;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p_multiplier.sv
// Bench for p_multiplier. Random and directed operations go through a driver.
// The driver queues the expected product and the completion cycle; an
// independent monitor checks each rising output_ready against that queue.
module tb_p_multiplier;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk;
  logic          reset;
  logic          input_ready;
  logic          output_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [PW-1:0] product;

  logic [PW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [PW-1:0] last_product;
  int            cyc;
  int            n_cmp;
  int            n_bad;

  p_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .input_ready  (input_ready),
    .output_ready (output_ready),
    .reset        (reset),
    .a            (a),
    .b            (b),
    .product      (product)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit, got cyc=%0d want finish", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: plain multiplication of the operand values.
  function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
`ifdef P_MULTIPLIER_SIGNED_EN
    xe = {{W{x[W-1]}}, x};
    ye = {{W{y[W-1]}}, y};
`else
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
`endif
    return xe * ye;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: each rising output_ready must match the head of the queue.
  // While output_ready stays high, product must not move.
  initial begin
    logic          prev_or;
    logic [PW-1:0] e;
    int            ec;
    prev_or = 1'b0;
    forever begin
      @(negedge clk);
      if (output_ready === 1'b1 && prev_or !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got product %h with no pending op, want none (cyc %0d)",
                   product, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("product", product, e);
          n_cmp++;
          if (cyc != ec) begin
            n_bad++;
            $display("FAIL latency: done at cyc %0d want %0d", cyc, ec);
          end
          last_product = e;
        end
      end else if (output_ready === 1'b1) begin
        check("product_stable", product, last_product);
      end
      prev_or = output_ready;
    end
  end

  // Driver task: run one operation. input_ready stays high for `hold` cycles counted from
  // the start edge. If chg_at > 0, a is overwritten during BUSY.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input int hold,
                       input int chg_at, input logic [W-1:0] chg_a);
    bit seen;
    @(posedge clk); #1;
    a = oa;
    b = ob;
    input_ready = 1'b1;
    @(posedge clk); #1;          // start edge E0 has been sampled
    exp_q.push_back(model(oa, ob));
    exp_cyc_q.push_back(cyc + W);
    check("ready_low_on_start", {{(PW-1){1'b0}}, output_ready}, '0);
    check("product_kept_on_start", product, last_product);
    seen = 1'b0;
    for (int k = 1; k <= hold + W + 4; k++) begin
      if (k >= hold) input_ready = 1'b0;
      if (k == chg_at) a = chg_a;
      if (output_ready === 1'b1) seen = 1'b1;
      if (seen && k >= hold) break;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL done_timeout: output_ready got 0 want 1 for a=%h b=%h", oa, ob);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_product = '0;
    reset = 1'b0;
    input_ready = 1'b1;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));

    // Reset with input_ready high and arbitrary operands.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_ready", {{(PW-1){1'b0}}, output_ready}, '0);
    check("reset_product", product, '0);
    reset = 1'b1;
    input_ready = 1'b0;
    idle(W + 3);
    check("idle_after_reset_ready", {{(PW-1){1'b0}}, output_ready}, '0);

    // Directed cases.
    do_op(8'd3, 8'd5, 1, 0, '0);
    idle(20);
    do_op(8'd255, 8'd255, 1, 0, '0);
    do_op(8'd0, 8'd200, 2, 0, '0);
    do_op(8'hFD, 8'd5, 1, 0, '0);
    do_op(8'd128, 8'd128, 1, 0, '0);
    do_op(8'd127, 8'd129, 1, 0, '0);
    do_op(8'd11, 8'd13, 30, 0, '0);       // held-high level: one completion only
    do_op(8'd6, 8'd7, 1, 4, 8'd9);        // a changed during BUSY

    // Mid-operation reset aborts the operation.
    @(posedge clk); #1;
    a = 8'd7;
    b = 8'd7;
    input_ready = 1'b1;
    @(posedge clk); #1;
    input_ready = 1'b0;
    idle(3);
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_cyc_q.delete();
    last_product = '0;
    check("midreset_ready", {{(PW-1){1'b0}}, output_ready}, '0);
    check("midreset_product", product, '0);
    reset = 1'b1;
    idle(W + 4);
    check("no_done_after_abort", {{(PW-1){1'b0}}, output_ready}, '0);
    do_op(8'd7, 8'd7, 1, 0, '0);

    // Random operations with random pulse widths, gaps and operand disturbances.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           ca;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, W)) : 0;
      do_op(ra, rb, int'($urandom_range(1, 3)), ca, W'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) b = W'($urandom_range(0, 255));
      idle(int'($urandom_range(0, 3)));
    end

    idle(W + 4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_at_end: got %0d queued want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
